// File: rtl/phy_init_pkg.sv
// Shared types and constants for the PHY bring-up sequencer.
package phy_init_pkg;

  // Sequencer states, from PHY hardware reset through register setup to a sticky result.
  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    RST_WAIT   = 3'd1,
    CMD_ISSUE  = 3'd2,
    CMD_WAIT   = 3'd3,
    IDLY_WAIT  = 3'd4,
    DONE       = 3'd5,
    ERROR      = 3'd6
  } state_t;

  // MDIO opcode for a register write.
  localparam logic [1:0] OP_WRITE = 2'b01;

  // One table entry is {reg[4:0], data[15:0]}; the table holds up to four entries.
  localparam int ENTRY_W     = 21;
  localparam int MAX_ENTRIES = 4;
  localparam int TABLE_W     = ENTRY_W * MAX_ENTRIES;

  // Largest of three cycle counts, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phy_init_sequencer.sv
// PHY power-up sequencer: holds the PHY in reset, waits for it to settle,
// writes a small register table through the MDIO master, then waits for
// IDELAYCTRL to report ready. Ends sticky in DONE or ERROR until restart.
module phy_init_sequencer
  import phy_init_pkg::*;
#(
  parameter int                 RESET_CYCLES   = 1250000,
  parameter int                 WAIT_CYCLES    = 6250000,
  parameter int                 TIMEOUT_CYCLES = 65535,
  parameter logic [4:0]         PHY_ADDR       = 5'd1,
  parameter int                 CFG_COUNT      = 2,
  parameter logic [TABLE_W-1:0] CFG_TABLE      = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        idelay_rdy,
  output logic        phy_reset_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_opcode,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  input  logic        mdio_busy,
  output logic        init_done,
  output logic        init_error,
  output logic        busy
);

  localparam int CNT_W = $clog2(max3(RESET_CYCLES, WAIT_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [1:0]         idx_reg, idx_next;
  logic               wait_first_reg, wait_first_next;

  logic               phy_reset_n_reg, cmd_valid_reg, init_done_reg, init_error_reg, busy_reg;
  logic [1:0]         cmd_opcode_reg;
  logic [4:0]         cmd_phy_addr_reg, cmd_reg_addr_reg;
  logic [15:0]        cmd_data_reg;

  // Unpack the flat parameter table into addressable entries.
  logic [ENTRY_W-1:0] entries [MAX_ENTRIES];
  for (genvar gi = 0; gi < MAX_ENTRIES; gi++) begin : g_entries
    assign entries[gi] = CFG_TABLE[gi*ENTRY_W +: ENTRY_W];
  end

  // Next state, shared counter and table index; restart overrides everything.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    wait_first_next = 1'b0;
    // Counter saturates rather than wrapping.
    cnt_inc         = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);
    case (state_reg)
      RST_ASSERT: begin
        if (cnt_reg >= RESET_LAST) begin
          state_next = RST_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      RST_WAIT: begin
        if (cnt_reg >= WAIT_LAST) begin
          state_next = (CFG_COUNT == 0) ? IDLY_WAIT : CMD_ISSUE;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      CMD_ISSUE: begin
        // The timeout keeps counting into CMD_WAIT; one budget per command.
        if (cmd_ready) begin
          state_next      = CMD_WAIT;
          cnt_next        = cnt_inc;
          wait_first_next = 1'b1;
        end else if (cnt_reg >= TIMEOUT_LAST) begin
          state_next = ERROR;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      CMD_WAIT: begin
        // The MDIO master raises busy a cycle after accepting, so the
        // first cycle here must not treat busy=0 as completion.
        if (!wait_first_reg && !mdio_busy) begin
          cnt_next = '0;
          if (int'(idx_reg) >= CFG_COUNT - 1) begin
            state_next = IDLY_WAIT;
          end else begin
            state_next = CMD_ISSUE;
            idx_next   = idx_reg + 2'd1;
          end
        end else if (cnt_reg >= TIMEOUT_LAST) begin
          state_next = ERROR;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      IDLY_WAIT: begin
        if (idelay_rdy) begin
          state_next = DONE;
        end
      end
      default: ;  // DONE and ERROR hold until restart
    endcase
    // Restart discards any in-flight command, even one accepted this cycle.
    if (restart) begin
      state_next      = RST_ASSERT;
      cnt_next        = '0;
      idx_next        = '0;
      wait_first_next = 1'b0;
    end
  end

  // State, counter and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RST_ASSERT;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      wait_first_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      wait_first_reg <= wait_first_next;
    end
  end

  // Registered outputs decoded from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      phy_reset_n_reg  <= 1'b0;
      cmd_valid_reg    <= 1'b0;
      init_done_reg    <= 1'b0;
      init_error_reg   <= 1'b0;
      busy_reg         <= 1'b1;
      cmd_opcode_reg   <= '0;
      cmd_phy_addr_reg <= '0;
      cmd_reg_addr_reg <= '0;
      cmd_data_reg     <= '0;
    end else begin
      phy_reset_n_reg <= (state_next != RST_ASSERT);
      cmd_valid_reg   <= (state_next == CMD_ISSUE);
      init_done_reg   <= (state_next == DONE);
      init_error_reg  <= (state_next == ERROR);
      busy_reg        <= (state_next != DONE) && (state_next != ERROR);
      // Index only moves on entry to CMD_ISSUE, so fields stay stable while offered.
      if (state_next == CMD_ISSUE) begin
        cmd_opcode_reg   <= OP_WRITE;
        cmd_phy_addr_reg <= PHY_ADDR;
        cmd_reg_addr_reg <= entries[idx_next][20:16];
        cmd_data_reg     <= entries[idx_next][15:0];
      end
    end
  end

  assign phy_reset_n  = phy_reset_n_reg;
  assign cmd_valid    = cmd_valid_reg;
  assign cmd_opcode   = cmd_opcode_reg;
  assign cmd_phy_addr = cmd_phy_addr_reg;
  assign cmd_reg_addr = cmd_reg_addr_reg;
  assign cmd_data     = cmd_data_reg;
  assign init_done    = init_done_reg;
  assign init_error   = init_error_reg;
  assign busy         = busy_reg;

endmodule
